sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock FIFO controller that sequences one simple dual-port synchronous RAM as a circular buffer.
//  Owns the write/read pointers, occupancy, flags and error reporting; drives the RAM's write port and registered read port.
//  Standard (non-show-ahead) read: data appears one cycle after an accepted read. Used as the generic buffering block between producer/consumer stages.
// PARAMETERS
//  DATA_WIDTH  8    word width, passed to RAM
//  ADDR_WIDTH  7    RAM address width; DEPTH = 2**ADDR_WIDTH entries
//  AF_THRESH   120  almost_full asserted when count >= AF_THRESH (1..DEPTH)
// PORTS
//  clk        in   1             single clock for controller and RAM (both RAM ports)
//  rst_n      in   1             asynchronous, active-low reset
//  flush      in   1             synchronous empty request
//  wr_en      in   1             write request
//  wr_data    in   DATA_WIDTH    write word
//  rd_en      in   1             read request
//  rd_data    out  DATA_WIDTH    read word, valid when rd_valid
//  rd_valid   out  1             pulses 1 cycle after an accepted read
//  full       out  1             count == DEPTH
//  empty      out  1             count == 0
//  almost_full out 1             count >= AF_THRESH
//  count      out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow   out  1             sticky: write requested while full
//  underflow  out  1             sticky: read requested while empty
//  clr_err    in   1             synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=underflow=0.
//  - wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; count = wr_ptr - rd_ptr (mod 2**(ADDR_WIDTH+1)); RAM address = ptr[ADDR_WIDTH-1:0]; wrap is natural.
//  - Flags are decoded from the current pointer registers (no next-state lookahead).
//  - wr_fire = wr_en & ~full; rd_fire = rd_en & ~empty; both evaluated on the current state.
//  - wr_fire: RAM wena=1, waddr=wr_ptr, din=wr_data; wr_ptr += 1 at the edge.
//  - rd_fire: RAM renb=1, raddr=rd_ptr; rd_ptr += 1; rd_data valid next cycle with rd_valid=1.
//  - rd_data holds its last value when no read fires; rd_valid is 0 in those cycles.
//  - Simultaneous wr_fire & rd_fire: both pointers advance; count is unchanged.
//  - Full with wr_en & rd_en: read fires, write is refused (overflow sets). No same-cycle pass-through.
//  - Empty with wr_en & rd_en: write fires, read is refused (underflow sets). No bypass.
//  - Read and write never target the same RAM address in one cycle, by construction; no collision logic.
//  - overflow: set on wr_en & full; underflow: set on rd_en & empty. Cleared by clr_err.
//    A set and a clr_err in the same cycle: set wins.
//  - flush: highest priority. Same-cycle wr_en/rd_en are ignored and raise no errors.
//    Next cycle: ptrs=0, count=0, empty=1, rd_valid=0. RAM contents and rd_data are untouched; errors are kept.
//  - Reset mid-operation: all state returns to reset values immediately; in-flight read is lost.
//  - Latency: write -> visible in count/empty next cycle; rd_en -> rd_data in 1 cycle.
// STRUCTURE
//  - Package fifo_pkg: localparam/function for DEPTH and PTR_W = ADDR_WIDTH+1, plus a count->flag decode helper.
//  - One sub-module: simple_dual_port_ram_sync instance (clka=clkb=clk, rst_n shared, wena=wr_fire, renb=rd_fire).
//  - Pointer/flag/error logic lives in this module; no separate FSM beyond pointer counters.
// TESTING
//  - Reset, then 3 writes (0x11,0x22,0x33) and 3 reads -> rd_data 0x11,0x22,0x33, each 1 cycle after rd_en; empty=1 at end, count 3->0.
//  - Fill 128 writes (ADDR_WIDTH=7) -> full=1, count=128, almost_full from the 120th write.
//    129th write -> refused, overflow=1; clr_err -> overflow=0.
//  - Full plus simultaneous wr_en & rd_en -> read returns oldest word; write dropped; count 127.
//    Then wrap: 200 interleaved writes/reads cross the pointer MSB with data order intact.
//  - Empty plus rd_en (with and without wr_en) -> rd_valid=0, underflow=1; simultaneous write lands, count=1.
//  - Steady wr_en & rd_en with count=5 for 50 cycles -> count stays 5, FIFO order preserved.
//  - flush with count=40 and wr_en=rd_en=1 -> next cycle count=0, empty=1, no errors.
//    rst_n pulse mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO controller.
//   depth_of / ptr_w_of : derive buffer depth and pointer width from the RAM address width
//   fifo_flags_t        : full / empty / almost_full bundle
//   decode_flags        : occupancy -> status flags
package fifo_pkg;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One extra pointer bit distinguishes full from empty when the addresses match.
  function automatic int ptr_w_of(input int addr_w);
    return addr_w + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
  } fifo_flags_t;

  function automatic fifo_flags_t decode_flags(input int unsigned cnt,
                                               input int unsigned depth,
                                               input int unsigned af_thresh);
    fifo_flags_t f;
    f.full        = (cnt == depth);
    f.empty       = (cnt == 0);
    f.almost_full = (cnt >= af_thresh);
    return f;
  endfunction

endpackage

// File: rtl/simple_dual_port_ram_sync.sv
// Simple dual-port synchronous RAM: one write port (A), one registered read port (B).
//   clka, wena, waddr, din : write port, word stored at the rising edge when wena=1
//   clkb, renb, raddr, dout: read port, dout updated one edge after renb=1, holds otherwise
//   rst_n                  : asynchronous active-low reset of the output register only
module simple_dual_port_ram_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clka,
  input  logic                  clkb,
  input  logic                  rst_n,
  input  logic                  wena,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  renb,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clka) begin
    if (wena) mem[waddr] <= din;
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n)    dout <= '0;
    else if (renb) dout <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving one simple dual-port RAM as a circular buffer.
// Standard (non-show-ahead) read: rd_data is valid one cycle after an accepted read.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous empty request, overrides wr_en/rd_en
//   wr_en, wr_data      : write request and word
//   rd_en               : read request
//   rd_data, rd_valid   : read word and its one-cycle valid pulse
//   full, empty, almost_full, count : occupancy status
//   overflow, underflow : sticky error flags, cleared by clr_err
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int AF_THRESH  = 120
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int PTR_W = ptr_w_of(ADDR_WIDTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] occ;
  fifo_flags_t      flags;
  logic             wr_fire;
  logic             rd_fire;
  logic             set_ovf;
  logic             set_udf;

  // Modular subtraction stays correct across the pointer MSB wrap.
  assign occ   = wr_ptr - rd_ptr;
  assign flags = decode_flags(32'(occ), 32'(DEPTH), 32'(AF_THRESH));

  assign count       = occ;
  assign full        = flags.full;
  assign empty       = flags.empty;
  assign almost_full = flags.almost_full;

  // Refusals are decided on the current state: no pass-through when full, no bypass when empty.
  assign wr_fire = wr_en & ~flags.full  & ~flush;
  assign rd_fire = rd_en & ~flags.empty & ~flush;
  assign set_ovf = wr_en & flags.full  & ~flush;
  assign set_udf = rd_en & flags.empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      end
      rd_valid <= rd_fire;
      // A new error event wins over a same-cycle clear.
      overflow  <= set_ovf | (overflow  & ~clr_err);
      underflow <= set_udf | (underflow & ~clr_err);
    end
  end

  simple_dual_port_ram_sync #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clka (clk),
    .clkb (clk),
    .rst_n(rst_n),
    .wena (wr_fire),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .din  (wr_data),
    .renb (rd_fire),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .dout (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 120;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of words plus the observable registers.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid;
  logic          m_ovf;
  logic          m_udf;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .clr_err    (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".count"},       32'(count),       32'(q.size()));
    chk({ctx, ".empty"},       32'(empty),       32'(q.size() == 0));
    chk({ctx, ".full"},        32'(full),        32'(q.size() == DEPTH));
    chk({ctx, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
    chk({ctx, ".rd_valid"},    32'(rd_valid),    32'(m_rd_valid));
    chk({ctx, ".rd_data"},     32'(rd_data),     32'(m_rd_data));
    chk({ctx, ".overflow"},    32'(overflow),    32'(m_ovf));
    chk({ctx, ".underflow"},   32'(underflow),   32'(m_udf));
  endtask

  task automatic model_reset();
    q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  // One clock cycle: drive, advance the model, check after the edge.
  task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd,
                      input logic fl, input logic ce, input string ctx);
    bit was_full, was_empty;
    wr_en = wr; wr_data = wd; rd_en = rd; flush = fl; clr_err = ce;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
      m_rd_valid = 1'b0;
      m_ovf = m_ovf & ~ce;
      m_udf = m_udf & ~ce;
    end else begin
      m_rd_valid = rd && !was_empty;
      if (m_rd_valid) m_rd_data = q.pop_front();
      if (wr && !was_full) q.push_back(wd);
      m_ovf = (wr && was_full)  || (m_ovf && !ce);
      m_udf = (rd && was_empty) || (m_udf && !ce);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, ctx);
  endtask

  initial begin
    int guard;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Basic order
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "wr1");
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, "wr2");
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, "wr3");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, "rd1");
    chk("rd1.lit", 32'(rd_data), 32'h11);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, "rd2");
    chk("rd2.lit", 32'(rd_data), 32'h22);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, "rd3");
    chk("rd3.lit", 32'(rd_data), 32'h33);
    idle("after3");
    chk("after3.empty_lit", 32'(empty), 32'd1);

    // Fill to full, then overflow and clear
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, "fill");
    chk("fill.full_lit", 32'(full), 32'd1);
    step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, "wr129");
    chk("wr129.ovf_lit", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr_ovf");
    chk("clr_ovf.lit", 32'(overflow), 32'd0);

    // Full with simultaneous write and read
    step(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0, "full_wr_rd");
    chk("full_wr_rd.count_lit", 32'(count), 32'd127);

    // Interleaved traffic across the pointer MSB
    for (int i = 0; i < 200; i++)
      step(1'($urandom), DW'($urandom), 1'($urandom), 1'b0, 1'b0, "wrap");
    for (int i = 0; i < 200; i++)
      step(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0, "wrap_both");

    // Drain, then read on empty with and without a write
    guard = 0;
    while (q.size() != 0 && guard < 2 * DEPTH) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, "drain");
      guard++;
    end
    chk("drain.bounded", 32'(q.size()), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr_before_udf");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, "udf_rd");
    chk("udf_rd.lit", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr_udf");
    step(1'b1, 8'h5a, 1'b1, 1'b0, 1'b0, "udf_wr_rd");
    chk("udf_wr_rd.count_lit", 32'(count), 32'd1);
    // A fresh error event wins over a same-cycle clear
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "pre_set_clr");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, "pre_set_clr2");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, "pre_set_clr3");
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, "set_vs_clr");

    // Steady-state streaming at count=5
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, "to5");
    for (int i = 0; i < 50; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0, "steady5");
    chk("steady5.count_lit", 32'(count), 32'd5);

    // Flush with pending traffic
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr_before_flush");
    while (q.size() < 40) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, "to40");
    step(1'b1, DW'($urandom), 1'b1, 1'b1, 1'b0, "flush");
    chk("flush.count_lit", 32'(count), 32'd0);

    // Random mix including occasional flush / clear
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 20) == 0), "rand");

    // Asynchronous reset mid-stream with a read in flight
    for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, "pre_rst");
    step(1'b1, 8'hee, 1'b1, 1'b0, 1'b0, "pre_rst_rd");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #3;
    rst_n = 1'b1;
    idle("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
